// File: rtl/brch_pred_ctrl.sv
// -----------------------------------------------------------------------------
// brch_pred_ctrl
// Branch condition resolution, branch history table (BHT) prediction and
// misprediction flush sequencing.
//
// Resolves the EX-stage branch condition over a DATA_W-bit signed operand,
// trains a direct-mapped table of 2-bit saturating counters indexed by
// pc[IDX_W+1:2], supplies a zero-latency prediction to IF, and raises a
// registered flush request for FLUSH_CYCLES cycles after each misprediction.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   if_pc             fetch PC used for the BHT lookup
//   if_pred_taken     BHT prediction for if_pc (combinational)
//   ex_valid/ex_stall EX holds a real instruction / EX is stalled
//   ex_cond           branch condition code (COND_*; others are non-branches)
//   ex_pc             PC of the EX instruction (BHT update index)
//   ex_pred_taken     prediction that travelled with the instruction
//   ex_rs, ex_rt      branch operands
//   brch              resolved taken (combinational)
//   mispredict        resolved direction differs from ex_pred_taken
//   flush             registered flush request to IF/ID
//   stat_branches     resolved-branch count
//   stat_mispred      misprediction count
//
// Optional feature: define BRCH_STAT_EN to build the saturating statistics
// counters; otherwise both stat outputs are tied to zero.
// -----------------------------------------------------------------------------
module brch_pred_ctrl #(
    parameter int DATA_W       = 32,
    parameter int PC_W         = 32,
    parameter int BHT_DEPTH    = 64,
    parameter int IDX_W        = 6,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PC_W-1:0]   if_pc,
    output logic              if_pred_taken,
    input  logic              ex_valid,
    input  logic              ex_stall,
    input  logic [3:0]        ex_cond,
    input  logic [PC_W-1:0]   ex_pc,
    input  logic              ex_pred_taken,
    input  logic [DATA_W-1:0] ex_rs,
    input  logic [DATA_W-1:0] ex_rt,
    output logic              brch,
    output logic              mispredict,
    output logic              flush,
    output logic [31:0]       stat_branches,
    output logic [31:0]       stat_mispred
);

    localparam logic [3:0] COND_BEQ  = 4'h1;
    localparam logic [3:0] COND_BNQ  = 4'h2;
    localparam logic [3:0] COND_BGEZ = 4'h3;
    localparam logic [3:0] COND_BGTZ = 4'h4;
    localparam logic [3:0] COND_BLEZ = 4'h5;
    localparam logic [3:0] COND_BLTZ = 4'h6;

    localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              flush_q, flush_d;
    logic [1:0]        bht_q [BHT_DEPTH];
    logic [1:0]        bht_d [BHT_DEPTH];

    logic [IDX_W-1:0]  if_idx;
    logic [IDX_W-1:0]  ex_idx;
    logic              cond_valid;
    logic              taken;
    logic              resolve;
    logic              rs_zero;
    logic              rs_neg;

    // PC bits outside the index field carry no information for this table.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{if_pc[PC_W-1:IDX_W+2], if_pc[1:0],
                              ex_pc[PC_W-1:IDX_W+2], ex_pc[1:0]};

    assign if_idx  = if_pc[IDX_W+1:2];
    assign ex_idx  = ex_pc[IDX_W+1:2];
    assign rs_zero = (ex_rs == '0);
    assign rs_neg  = ex_rs[DATA_W-1];

    // Condition decode; unknown codes are treated as non-branch instructions.
    always_comb begin
        taken      = 1'b0;
        cond_valid = 1'b1;
        case (ex_cond)
            COND_BEQ:  taken = (ex_rs == ex_rt);
            COND_BNQ:  taken = (ex_rs != ex_rt);
            COND_BGEZ: taken = ~rs_neg;
            COND_BGTZ: taken = ~rs_neg & ~rs_zero;
            COND_BLEZ: taken = rs_neg | rs_zero;
            COND_BLTZ: taken = rs_neg;
            default:   cond_valid = 1'b0;
        endcase
    end

    // EX inputs are ignored entirely while a flush is in progress.
    assign resolve       = ex_valid & ~ex_stall & (state_q == ST_IDLE) & cond_valid;
    assign brch          = resolve & taken;
    assign mispredict    = resolve & (taken != ex_pred_taken);
    assign if_pred_taken = bht_q[if_idx][1];
    assign flush         = flush_q;

    // Saturating counter update of the resolved entry only.
    always_comb begin
        bht_d = bht_q;
        if (resolve) begin
            if (taken) begin
                if (bht_q[ex_idx] != 2'b11) bht_d[ex_idx] = bht_q[ex_idx] + 2'b01;
            end else begin
                if (bht_q[ex_idx] != 2'b00) bht_d[ex_idx] = bht_q[ex_idx] - 2'b01;
            end
        end
    end

    // Flush sequencer: cnt counts remaining flush cycles after the current one.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (resolve && mispredict) begin
                    state_d = ST_FLUSH;
                    cnt_d   = CNT_INIT;
                end
            end
            ST_FLUSH: begin
                if (cnt_q == 4'd0) state_d = ST_IDLE;
                else               cnt_d   = cnt_q - 4'd1;
            end
            default: state_d = ST_IDLE;
        endcase
        flush_d = (state_d == ST_FLUSH);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            flush_q <= 1'b0;
            for (int i = 0; i < BHT_DEPTH; i++) bht_q[i] <= 2'b01;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            flush_q <= flush_d;
            bht_q   <= bht_d;
        end
    end

`ifdef BRCH_STAT_EN
    logic [31:0] stat_branches_q, stat_branches_d;
    logic [31:0] stat_mispred_q,  stat_mispred_d;

    // Statistics saturate instead of wrapping so long runs stay meaningful.
    always_comb begin
        stat_branches_d = stat_branches_q;
        stat_mispred_d  = stat_mispred_q;
        if (resolve && stat_branches_q != 32'hFFFF_FFFF)
            stat_branches_d = stat_branches_q + 32'd1;
        if (resolve && mispredict && stat_mispred_q != 32'hFFFF_FFFF)
            stat_mispred_d = stat_mispred_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_branches_q <= 32'd0;
            stat_mispred_q  <= 32'd0;
        end else begin
            stat_branches_q <= stat_branches_d;
            stat_mispred_q  <= stat_mispred_d;
        end
    end

    assign stat_branches = stat_branches_q;
    assign stat_mispred  = stat_mispred_q;
`else
    assign stat_branches = 32'd0;
    assign stat_mispred  = 32'd0;
`endif

endmodule
